hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TO_MAX, default 255, meaning memory-wait cycles before a timeout error is flagged.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low (asserted at 0).
REQ-004 SHALL have ports ifid_rs, ifid_rt, input, 5 each, source registers of the instruction in ID.
REQ-005 SHALL have ports idex_rs, idex_rt, input, 5 each, and idex_mem_read, input, 1, the operands and load flag held in ID/EX.
REQ-006 SHALL have ports exmem_rd, input, 5, exmem_reg_write, input, 1, and exmem_mem_access, input, 1, the EX/MEM destination, write-enable and memory access.
REQ-007 SHALL have ports memwb_rd, input, 5, and memwb_reg_write, input, 1, the MEM/WB destination and write-enable.
REQ-008 SHALL have ports branch_taken, input, 1, (EX resolved) and jump_id, input, 1, (jump decoded in ID).
REQ-009 SHALL have port dmem_ready, input, 1, data-memory completion for the current EX/MEM access.
REQ-010 SHALL have ports pc_write, ifid_write, idex_write, exmem_write, output, 1 each, pipeline register enables.
REQ-011 SHALL have ports ifid_flush and idex_bubble, output, 1 each; idex_bubble zeroes all control fields loaded into ID/EX.
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2 each: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-013 SHALL have ports stall_cnt and flush_cnt, output, 16 each, and mem_err, output, 1, a sticky timeout flag.

Function
REQ-014 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT; control outputs are combinational from state and inputs.
REQ-015 SHALL apply event priority MEM_WAIT condition > branch_taken > load-use > jump_id.
REQ-016 SHALL detect load-use when idex_mem_read=1, idex_rt!=0 and idex_rt equals ifid_rs or ifid_rt.
REQ-017 SHALL, on a load-use in RUN: pc_write=0, ifid_write=0, idex_bubble=1, then go to LU_STALL.
REQ-018 SHALL ignore load-use detection in LU_STALL, so that exactly one bubble is inserted, then return to RUN.
REQ-019 SHALL, on branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1; any simultaneous load-use or jump is discarded.
REQ-020 SHALL, on jump_id without branch_taken: ifid_flush=1, pc_write=1, idex_bubble=0.
REQ-021 SHALL, in RUN or LU_STALL when exmem_mem_access=1 and dmem_ready=0, drive all four enables to 0 with no flush or bubble, and enter MEM_WAIT in the same cycle.
REQ-022 SHALL hold all enables at 0 in MEM_WAIT until dmem_ready=1; in that cycle the enables are released and the state goes to RUN.
REQ-023 SHALL set mem_err after MEM_TO_MAX consecutive MEM_WAIT cycles; mem_err is cleared only by reset, and the wait continues.
REQ-024 SHALL forward with EX/MEM priority: fwd_a=10 if exmem_reg_write, exmem_rd!=0 and exmem_rd==idex_rs; otherwise 01 on the same MEM/WB match; otherwise 00. fwd_b does the same using idex_rt.
REQ-025 SHALL never forward from or stall on register 0.
REQ-026 SHALL increment stall_cnt on every cycle with pc_write=0, and flush_cnt on every cycle with ifid_flush=1; both saturate at 0xFFFF.
REQ-027 SHALL drive all enables to 1, and flush, bubble and fwd to 0, when no event is present in RUN.

Reset
REQ-028 SHALL, while rst=0: state RUN, counters 0, mem_err 0, wait counter 0; outputs pc_write, ifid_write, idex_write, exmem_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
REQ-029 SHALL abandon any stall or MEM_WAIT immediately on reset assertion, mid-operation.

Structure
REQ-030 SHALL place the FSM state encoding, FWD_RF/FWD_EXMEM/FWD_MEMWB constants and the MEM_TO_MAX default in a shared package, hazard_pkg.
REQ-031 SHALL implement forwarding as one combinational sub-module, fwd_unit; the FSM and counters stay in hazard_ctrl.

Verification
REQ-032 SHALL test load-use: idex_mem_read=1, idex_rt=5, ifid_rs=5 -> one cycle of pc_write=0, idex_bubble=1, then RUN; stall_cnt=1.
REQ-033 SHALL test a branch during load-use: branch_taken=1 with a load-use present -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt=0.
REQ-034 SHALL test forwarding: exmem_rd=memwb_rd=7, both reg_write=1, idex_rs=7 -> fwd_a=10; with exmem_rd=0 -> fwd_a=01.
REQ-035 SHALL test memory wait: exmem_mem_access=1, dmem_ready=0 for 3 cycles -> enables 0 for 3 cycles, released on the dmem_ready cycle; stall_cnt=3.
REQ-036 SHALL test timeout: dmem_ready held 0 for MEM_TO_MAX cycles -> mem_err=1 and sticky after ready; asserting rst=0 mid-wait -> RUN with all enables 1.
REQ-037 SHALL test register 0: idex_mem_read=1, idex_rt=0, ifid_rs=0 -> no stall, fwd_a=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package hazard_pkg;

  // Controller states: normal flow, the single load-use bubble cycle,
  // and the data-memory wait.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Operand source selects for the EX stage muxes.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Default number of memory-wait cycles before the timeout flag is raised.
  localparam int MEM_TO_MAX_DEF = 255;

  // Saturating 16-bit increment for the event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding unit: selects EX operand sources from EX/MEM and MEM/WB.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs every cycle.
//
// Ports: idex_rs/idex_rt are the EX operands, exmem_*/memwb_* describe the
// two in-flight writers, fwd_a/fwd_b are the select codes from hazard_pkg.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // EX/MEM holds the younger result, so it wins over MEM/WB. Register 0 is
  // hard-wired zero and must never be forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] em_rd,
    input logic       em_we,
    input logic [4:0] mw_rd,
    input logic       mw_we
  );
    if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
      return FWD_EXMEM;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign fwd_a = fwd_sel(idex_rs, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
  assign fwd_b = fwd_sel(idex_rt, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory wait.
// Latency: control outputs are combinational from state and inputs; state,
// counters and mem_err update on the next rising clk edge.
// Backpressure: dmem_ready=0 on an EX/MEM access freezes all four pipeline
// register enables until the memory completes.
//
// Ports: ifid_*/idex_*/exmem_*/memwb_* describe pipeline register contents;
// branch_taken/jump_id are control-flow events; dmem_ready is memory
// completion. Outputs are the four register enables, ifid_flush,
// idex_bubble, fwd_a/fwd_b, saturating stall_cnt/flush_cnt and sticky mem_err.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TO_MAX = MEM_TO_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic [4:0]  idex_rs,
  input  logic [4:0]  idex_rt,
  input  logic        idex_mem_read,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_reg_write,
  input  logic        exmem_mem_access,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_reg_write,
  input  logic        branch_taken,
  input  logic        jump_id,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);

  localparam int                WAIT_W     = $clog2(MEM_TO_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TO_MAX);
  localparam logic [WAIT_W-1:0] WAIT_TRIP  = WAIT_W'(MEM_TO_MAX - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  logic       load_use;
  logic       mem_block;
  logic       mem_hold;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       flush;
  logic       bubble;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // A load in EX whose destination is read by the instruction in ID.
  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Memory access in EX/MEM that has not completed this cycle.
  assign mem_block = exmem_mem_access && !dmem_ready;

  fwd_unit u_fwd (
    .idex_rs         (idex_rs),
    .idex_rt         (idex_rt),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .fwd_a           (fwd_a_raw),
    .fwd_b           (fwd_b_raw)
  );

  // Next state and raw control. Priority: memory wait, branch, load-use,
  // jump. The cycle that releases a memory wait is a plain pass-through.
  always_comb begin
    state_nxt = RUN;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    mem_hold  = 1'b0;
    case (state)
      MEM_WAIT: begin
        if (!dmem_ready) begin
          mem_hold  = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      RUN, LU_STALL: begin
        if (mem_block) begin
          mem_hold  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (branch_taken) begin
          // Wrong-path instructions in IF/ID and ID are both squashed.
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (load_use && (state == RUN)) begin
          // Only one bubble per load: LU_STALL ignores the still-visible hazard.
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          bubble    = 1'b1;
          state_nxt = LU_STALL;
        end else if (jump_id) begin
          flush = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (mem_hold) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end
  end

  // While reset is asserted the outputs show the idle values regardless of
  // whatever the pipeline inputs are doing.
  assign pc_write    = pc_en    | ~rst;
  assign ifid_write  = ifid_en  | ~rst;
  assign idex_write  = idex_en  | ~rst;
  assign exmem_write = exmem_en | ~rst;
  assign ifid_flush  = flush  & rst;
  assign idex_bubble = bubble & rst;
  assign fwd_a       = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b       = rst ? fwd_b_raw : FWD_RF;

  // wait_cnt counts consecutive memory-hold cycles, including the cycle that
  // enters the wait, so the flag trips once dmem_ready has been low for
  // MEM_TO_MAX cycles. The wait itself carries on after the flag is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
      mem_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_write) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
      if (ifid_flush) begin
        flush_cnt <= sat_inc16(flush_cnt);
      end
      if (mem_hold) begin
        if (wait_cnt != WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        if (wait_cnt >= WAIT_TRIP) begin
          mem_err <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic.
// Latency: n/a.
// Backpressure: dmem_ready is driven both in directed waits and randomly.
module tb_hazard_ctrl;

    localparam int TO = 255;

    logic        clk;
    logic        rst;
    logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic        idex_mem_read, exmem_reg_write, exmem_mem_access;
    logic        memwb_reg_write, branch_taken, jump_id, dmem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_bubble, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    bit m_lu_prev;
    bit m_wait_prev;
    int m_wlen;
    int m_stall;
    int m_flush;
    bit m_err;

    hazard_ctrl #(.MEM_TO_MAX(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifid_rs          (ifid_rs),
        .ifid_rt          (ifid_rt),
        .idex_rs          (idex_rs),
        .idex_rt          (idex_rt),
        .idex_mem_read    (idex_mem_read),
        .exmem_rd         (exmem_rd),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_access (exmem_mem_access),
        .memwb_rd         (memwb_rd),
        .memwb_reg_write  (memwb_reg_write),
        .branch_taken     (branch_taken),
        .jump_id          (jump_id),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .idex_write       (idex_write),
        .exmem_write      (exmem_write),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .mem_err          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (exmem_reg_write && exmem_rd == src) return 2'b10;
        if (memwb_reg_write && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
        exmem_rd = 5'd0; memwb_rd = 5'd0;
        idex_mem_read = 1'b0; exmem_reg_write = 1'b0; exmem_mem_access = 1'b0;
        memwb_reg_write = 1'b0; branch_taken = 1'b0; jump_id = 1'b0;
        dmem_ready = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #2;
        chk(tag, "pc_write", pc_write, 1'b1);
        chk(tag, "ifid_write", ifid_write, 1'b1);
        chk(tag, "idex_write", idex_write, 1'b1);
        chk(tag, "exmem_write", exmem_write, 1'b1);
        chk(tag, "ifid_flush", ifid_flush, 1'b0);
        chk(tag, "idex_bubble", idex_bubble, 1'b0);
        chk(tag, "fwd_a", fwd_a, 2'b00);
        chk(tag, "fwd_b", fwd_b, 2'b00);
        chk(tag, "stall_cnt", stall_cnt, 16'd0);
        chk(tag, "flush_cnt", flush_cnt, 16'd0);
        chk(tag, "mem_err", mem_err, 1'b0);
        m_lu_prev = 1'b0; m_wait_prev = 1'b0; m_wlen = 0;
        m_stall = 0; m_flush = 0; m_err = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic step(input string tag);
        logic lu, hold, e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bub;
        logic [1:0] e_fa, e_fb;
        @(negedge clk);
        lu = idex_mem_read && idex_rt != 5'd0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        hold = m_wait_prev ? !dmem_ready : (exmem_mem_access && !dmem_ready);
        e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_exmem = 1'b1;
        e_flush = 1'b0; e_bub = 1'b0;
        if (hold) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0;
        end else if (m_wait_prev) begin
            e_pc = 1'b1;
        end else if (branch_taken) begin
            e_flush = 1'b1; e_bub = 1'b1;
        end else if (lu && !m_lu_prev) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
        end else if (jump_id) begin
            e_flush = 1'b1;
        end
        e_fa = fwd_ref(idex_rs);
        e_fb = fwd_ref(idex_rt);
        chk(tag, "pc_write", pc_write, e_pc);
        chk(tag, "ifid_write", ifid_write, e_ifid);
        chk(tag, "idex_write", idex_write, e_idex);
        chk(tag, "exmem_write", exmem_write, e_exmem);
        chk(tag, "ifid_flush", ifid_flush, e_flush);
        chk(tag, "idex_bubble", idex_bubble, e_bub);
        chk(tag, "fwd_a", fwd_a, e_fa);
        chk(tag, "fwd_b", fwd_b, e_fb);
        chk(tag, "stall_cnt", stall_cnt, 16'(m_stall));
        chk(tag, "flush_cnt", flush_cnt, 16'(m_flush));
        chk(tag, "mem_err", mem_err, m_err);
        @(posedge clk);
        m_lu_prev = !e_pc && !hold;
        m_wait_prev = hold;
        if (!e_pc && m_stall < 65535) m_stall++;
        if (e_flush && m_flush < 65535) m_flush++;
        m_wlen = hold ? m_wlen + 1 : 0;
        if (m_wlen >= TO) m_err = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        apply_reset("reset");

        idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        step("lu_first");
        step("lu_second");
        clear_inputs();
        step("lu_after");
        chk("lu", "stall_cnt_total", stall_cnt, 16'd1);
        chk("lu", "flush_cnt_total", flush_cnt, 16'd0);

        apply_reset("rst_br");
        idex_mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        branch_taken = 1'b1; jump_id = 1'b1;
        #1;
        chk("br", "pc_write_now", pc_write, 1'b1);
        chk("br", "flush_now", ifid_flush, 1'b1);
        step("br_lu");
        clear_inputs();
        step("br_after");
        chk("br", "flush_cnt_total", flush_cnt, 16'd1);
        chk("br", "stall_cnt_total", stall_cnt, 16'd0);

        jump_id = 1'b1;
        step("jump");
        clear_inputs();

        exmem_rd = 5'd7; memwb_rd = 5'd7; exmem_reg_write = 1'b1; memwb_reg_write = 1'b1;
        idex_rs = 5'd7; idex_rt = 5'd7;
        #1;
        chk("fwd", "fwd_a_exmem", fwd_a, 2'b10);
        step("fwd_both");
        exmem_rd = 5'd0;
        #1;
        chk("fwd", "fwd_a_memwb", fwd_a, 2'b01);
        step("fwd_memwb");
        clear_inputs();

        idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; idex_rs = 5'd0;
        exmem_reg_write = 1'b1; memwb_reg_write = 1'b1;
        step("r0");
        chk("r0", "stall_cnt_total", stall_cnt, 16'd0);
        clear_inputs();

        apply_reset("rst_mw");
        exmem_mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mw_hold");
        dmem_ready = 1'b1;
        step("mw_release");
        exmem_mem_access = 1'b0;
        step("mw_after");
        chk("mw", "stall_cnt_total", stall_cnt, 16'd3);

        apply_reset("rst_to");
        exmem_mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TO; i++) step("to_hold");
        chk("to", "mem_err_set", mem_err, 1'b1);
        step("to_hold_more");
        dmem_ready = 1'b1;
        step("to_release");
        exmem_mem_access = 1'b0;
        step("to_after");
        chk("to", "mem_err_sticky", mem_err, 1'b1);

        exmem_mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("to_rewait");
        apply_reset("rst_midwait");
        step("post_midwait");

        for (int n = 0; n < 1500; n++) begin
            ifid_rs = 5'($urandom_range(0, 7));
            ifid_rt = 5'($urandom_range(0, 7));
            idex_rs = 5'($urandom_range(0, 7));
            idex_rt = 5'($urandom_range(0, 7));
            exmem_rd = 5'($urandom_range(0, 7));
            memwb_rd = 5'($urandom_range(0, 7));
            idex_mem_read = ($urandom_range(0, 2) == 0);
            exmem_reg_write = ($urandom_range(0, 1) == 0);
            memwb_reg_write = ($urandom_range(0, 1) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            jump_id = ($urandom_range(0, 7) == 0);
            exmem_mem_access = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                apply_reset("rand_rst");
            end else begin
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
